// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, ROM interface and a small {pc, inst} queue toward decode.
// Define IF_ALIGN_CHECK_EN to add addr_err for misaligned branch targets.
module inst_fetch #(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   q_pc   [QUEUE_DEPTH];
  logic [31:0]   q_inst [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          fetch_ok;
  logic [31:0]   tgt;

`ifdef IF_ALIGN_CHECK_EN
  assign fetch_ok = ~addr_err;
  assign tgt      = branch_target;
`else
  assign fetch_ok = 1'b1;
  assign tgt      = branch_target & 32'hFFFF_FFFC;
`endif

  assign rom_addr = pc;
  assign if_valid = (count != '0);
  assign if_inst  = q_inst[rd_ptr];
  assign if_pc    = q_pc[rd_ptr];

  assign pop  = if_valid & if_ready & ~branch_flag;
  assign push = rom_ce & ~stall & ~branch_flag & fetch_ok
              & ((count < FULL) | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      rom_ce <= 1'b0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
`ifdef IF_ALIGN_CHECK_EN
      addr_err <= 1'b0;
`endif
    end else begin
      rom_ce <= 1'b1;
      if (branch_flag) begin
        pc     <= tgt;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
`ifdef IF_ALIGN_CHECK_EN
        addr_err <= |branch_target[1:0];
`endif
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage needs no reset: count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= pc;
      q_inst[wr_ptr] <= rom_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table plus randomized run
// against a queue-based reference model.
module tb_inst_fetch;

  localparam int D = 2;

  logic        clk;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
`ifdef IF_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  int n_chk = 0;
  int n_pass = 0;

  inst_fetch #(.QUEUE_DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .rom_ce(rom_ce),
    .rom_addr(rom_addr),
    .rom_inst(rom_inst),
    .stall(stall),
    .branch_flag(branch_flag),
    .branch_target(branch_target),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_inst(if_inst),
    .if_pc(if_pc)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .addr_err(addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h3C01_0001;
    if (a == 32'h4) return 32'h3421_0002;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign rom_inst = rom_fn(rom_addr);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ready;
    logic        e_ce;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic b,
                     input logic [31:0] t, input logic rd,
                     input logic ce, input logic v,
                     input logic [31:0] p, input logic [31:0] a,
                     input logic e);
    vec_t x;
    x.rst = r; x.stall = s; x.br = b; x.tgt = t; x.ready = rd;
    x.e_ce = ce; x.e_valid = v; x.e_pc = p; x.e_addr = a; x.e_err = e;
    vecs.push_back(x);
  endtask

  // Reference model state
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic        m_ce;
  logic        m_err;

  task automatic model_step(input logic r, input logic s, input logic b,
                            input logic [31:0] t, input logic rd);
    logic pop_m;
    logic push_m;
    if (r) begin
      mq.delete();
      m_pc = 0; m_ce = 0; m_err = 0;
    end else if (b) begin
      mq.delete();
`ifdef IF_ALIGN_CHECK_EN
      m_pc = t;
      m_err = (t % 4) != 0;
`else
      m_pc = t - (t % 4);
`endif
      m_ce = 1;
    end else begin
      pop_m  = (mq.size() != 0) && rd;
      push_m = m_ce && !s && !m_err && ((mq.size() < D) || pop_m);
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        mq.push_back({m_pc, rom_fn(m_pc)});
        m_pc = m_pc + 4;
      end
      m_ce = 1;
    end
  endtask

  initial begin
    logic al;
    al = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    al = 1'b1;
`endif
    rst = 1; stall = 0; branch_flag = 0; branch_target = 0; if_ready = 0;

    //   rst s  b  tgt            rdy ce v  pc             addr           err
    add(1, 0, 0, 0,             0,  0, 0, 0,             32'h0,         0);
    add(1, 0, 0, 0,             0,  0, 0, 0,             32'h0,         0);
    add(0, 0, 0, 0,             0,  1, 0, 0,             32'h0,         0);
    add(0, 0, 0, 0,             0,  1, 1, 32'h0,         32'h4,         0);
    add(0, 0, 0, 0,             0,  1, 1, 32'h0,         32'h8,         0);
    add(0, 0, 0, 0,             0,  1, 1, 32'h0,         32'h8,         0);
    add(0, 0, 0, 0,             1,  1, 1, 32'h4,         32'hC,         0);
    add(0, 0, 0, 0,             1,  1, 1, 32'h8,         32'h10,        0);
    add(0, 0, 1, 32'h100,       0,  1, 0, 0,             32'h100,       0);
    add(0, 0, 0, 0,             0,  1, 1, 32'h100,       32'h104,       0);
    add(1, 0, 0, 0,             1,  0, 0, 0,             32'h0,         0);
    add(0, 0, 0, 0,             1,  1, 0, 0,             32'h0,         0);
    add(0, 0, 0, 0,             1,  1, 1, 32'h0,         32'h4,         0);
    add(0, 0, 0, 0,             1,  1, 1, 32'h4,         32'h8,         0);
    add(0, 0, 0, 0,             1,  1, 1, 32'h8,         32'hC,         0);
    add(0, 1, 0, 0,             1,  1, 0, 0,             32'hC,         0);
    add(0, 1, 0, 0,             1,  1, 0, 0,             32'hC,         0);
    add(0, 1, 0, 0,             1,  1, 0, 0,             32'hC,         0);
    add(0, 0, 0, 0,             1,  1, 1, 32'hC,         32'h10,        0);
    if (al) begin
      add(0, 0, 1, 32'h102,     1,  1, 0, 0,             32'h102,       1);
      add(0, 0, 0, 0,           1,  1, 0, 0,             32'h102,       1);
    end else begin
      add(0, 0, 1, 32'h102,     1,  1, 0, 0,             32'h100,       0);
      add(0, 0, 0, 0,           1,  1, 1, 32'h100,       32'h104,       0);
    end
    add(0, 1, 1, 32'h200,       1,  1, 0, 0,             32'h200,       0);
    add(0, 0, 0, 0,             1,  1, 1, 32'h200,       32'h204,       0);
    add(0, 0, 1, 32'hFFFFFFFC,  1,  1, 0, 0,             32'hFFFFFFFC,  0);
    add(0, 0, 0, 0,             1,  1, 1, 32'hFFFFFFFC,  32'h0,         0);
    add(0, 0, 0, 0,             1,  1, 1, 32'h0,         32'h4,         0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; stall = vecs[i].stall;
      branch_flag = vecs[i].br; branch_target = vecs[i].tgt;
      if_ready = vecs[i].ready;
      @(posedge clk); #1;
      chk($sformatf("v%0d rom_ce", i), 32'(rom_ce), 32'(vecs[i].e_ce));
      chk($sformatf("v%0d if_valid", i), 32'(if_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d rom_addr", i), rom_addr, vecs[i].e_addr);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d if_pc", i), if_pc, vecs[i].e_pc);
        chk($sformatf("v%0d if_inst", i), if_inst, rom_fn(vecs[i].e_pc));
      end
`ifdef IF_ALIGN_CHECK_EN
      chk($sformatf("v%0d addr_err", i), 32'(addr_err), 32'(vecs[i].e_err));
`endif
    end

    // Randomized run against the reference model
    for (int c = 0; c < 400; c++) begin
      logic r, s, b, rd;
      logic [31:0] t;
      r  = (c < 2) || ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 2) != 0);
      t  = $urandom;
      if ($urandom_range(0, 3) != 0) t = t & 32'hFFFF_FFFC;
      rst = r; stall = s; branch_flag = b; branch_target = t; if_ready = rd;
      model_step(r, s, b, t, rd);
      @(posedge clk); #1;
      chk("rnd rom_ce", 32'(rom_ce), 32'(m_ce));
      chk("rnd rom_addr", rom_addr, m_pc);
      chk("rnd if_valid", 32'(if_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("rnd if_pc", if_pc, mq[0][63:32]);
        chk("rnd if_inst", if_inst, mq[0][31:0]);
      end
`ifdef IF_ALIGN_CHECK_EN
      chk("rnd addr_err", 32'(addr_err), 32'(m_err));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 2, meaning the number of fetched-instruction queue entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port rom_ce, output, 1 bit: chip enable to the instruction ROM.
REQ-005 SHALL have port rom_addr, output, 32 bits: byte address to the ROM; equals the current PC.
REQ-006 SHALL have port rom_inst, input, 32 bits: ROM data, combinationally valid in the same cycle as rom_addr.
REQ-007 SHALL have port stall, input, 1 bit: pipeline-control stall; holds the PC and blocks pushes.
REQ-008 SHALL have port branch_flag, input, 1 bit: redirect request.
REQ-009 SHALL have port branch_target, input, 32 bits: redirect byte address.
REQ-010 SHALL have port if_valid, output, 1 bit: the queue head holds a valid instruction.
REQ-011 SHALL have port if_ready, input, 1 bit: decode accepts the head.
REQ-012 SHALL have port if_inst, output, 32 bits: instruction at the queue head.
REQ-013 SHALL have port if_pc, output, 32 bits: PC of the queue head.

Function
REQ-014 SHALL hold registers pc (32 bits), a registered rom_ce, and a QUEUE_DEPTH-entry FIFO of {pc, inst} with read pointer, write pointer and count.
REQ-015 SHALL drive rom_ce as a register: cleared by reset, set on the first rising edge with rst low, and held at 1 thereafter.
REQ-016 SHALL define push = rom_ce & ~stall & ~branch_flag & (count < QUEUE_DEPTH | pop).
REQ-017 SHALL define pop = if_valid & if_ready & ~branch_flag.
REQ-018 SHALL, on push, write {pc, rom_inst} at the write pointer and set pc to pc+4, truncated to 32 bits, so 0xFFFFFFFC wraps to 0x00000000.
REQ-019 SHALL hold pc whenever there is no push and no branch.
REQ-020 SHALL drive if_valid = (count != 0), and SHALL drive if_inst/if_pc combinationally from the read-pointer entry.
REQ-021 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-022 SHALL wrap both pointers modulo QUEUE_DEPTH.
REQ-023 SHALL, when branch_flag=1, clear count and both pointers and load pc with branch_target, with no push or pop that cycle.
REQ-024 SHALL give branch_flag priority over stall, pop and push.
REQ-025 SHALL give 1-cycle fetch-to-valid latency: an instruction pushed at edge N is visible on if_valid/if_inst after edge N.
REQ-026 SHALL ensure if_inst/if_pc remain stable while if_valid=1 and if_ready=0.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set pc=0x00000000, rom_ce=0, count=0 and pointers=0, so that if_valid=0.
REQ-028 SHALL let reset asserted mid-operation discard all queued entries and override branch_flag and stall.

Configuration
REQ-029 SHALL support the macro IF_ALIGN_CHECK_EN, which selects between REQ-030 and REQ-031.
REQ-030 SHALL, when IF_ALIGN_CHECK_EN is defined, add output port addr_err (1 bit), which is set when a branch loads a target with bits [1:0] != 0, is cleared by reset or by a subsequent aligned branch, and blocks all pushes while set.
REQ-031 SHALL, when IF_ALIGN_CHECK_EN is undefined, omit addr_err and force branch_target[1:0] to 00 when loading pc.

Verification
REQ-032 SHALL be verified with: hold rst=1 for 2 cycles, then release -> rom_ce=0 and if_valid=0 during reset; rom_ce=1 one edge after release; rom_addr=0x0.
REQ-033 SHALL be verified with: rom returns 0x3C010001 at 0x0 and 0x34210002 at 0x4, with if_ready=1 -> if_pc/if_inst are 0x0/0x3C010001 then 0x4/0x34210002 on consecutive cycles.
REQ-034 SHALL be verified with: if_ready=0 from reset -> count saturates at 2 and pc holds at 0x8 with rom_addr=0x8; raising if_ready resumes one push and one pop per cycle.
REQ-035 SHALL be verified with: a full queue plus one-cycle branch_flag with target 0x100 -> if_valid=0 after that edge, rom_addr=0x100, and the next head is pc 0x100.
REQ-036 SHALL be verified with: stall=1 for 3 cycles with if_ready=1 -> queue drains, pc is unchanged, and no new entries are written.
REQ-037 SHALL be verified with: a branch to 0x102 -> addr_err=1 and no pushes when IF_ALIGN_CHECK_EN is defined; fetch from 0x100 when it is undefined.
